// File: rtl/cic_sched_if.sv
// Control/handshake bundle between a CIC integrator/decimator datapath and its scheduler.
// The master side offers samples and configuration; the slave (scheduler) drives the datapath controls.
interface cic_sched_if #(
  parameter int CNTW = 12
);
  logic            mode;
  logic [CNTW-1:0] rate;
  logic            load;
  logic            in_vld;
  logic            in_ch;
  logic            in_rdy;
  logic            int_zero;
  logic            int_n;
  logic            int_rst;
  logic            dec_stb;
  logic            dec_ch;
  logic            busy;

  modport master (
    output mode, rate, load, in_vld, in_ch,
    input  in_rdy, int_zero, int_n, int_rst, dec_stb, dec_ch, busy
  );

  modport slave (
    input  mode, rate, load, in_vld, in_ch,
    output in_rdy, int_zero, int_n, int_rst, dec_stb, dec_ch, busy
  );
endinterface

// File: rtl/cic_sched.sv
// CIC scheduler: sequences integrator clears, interleaves up to two channels and
// emits a decimation strobe aligned with the one-register integrator latency.
module cic_sched #(
  parameter int CNTW  = 12,
  parameter int FLUSH = 4
) (
  input  logic          clk,
  input  logic          rst,
  cic_sched_if.slave    bus
);

  localparam int FW = (FLUSH > 1) ? $clog2(FLUSH) : 1;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]      r_state;
  logic [FW-1:0]   r_fcnt;
  logic            r_mode;
  logic [CNTW-1:0] r_rate;
  logic            r_phase;
  logic [CNTW-1:0] r_cnt [2];
  logic            r_dec_stb;
  logic            r_dec_ch;

  logic w_run;
  logic w_last;
  logic w_rdy;
  logic w_acc;
  logic w_ch;
  logic w_wrap;

  assign w_run  = (r_state == ST_RUN);
  assign w_last = (r_fcnt == FW'(FLUSH - 1));
  assign w_rdy  = w_run & ~bus.load & (r_mode ? (r_phase == bus.in_ch) : 1'b1);
  assign w_acc  = bus.in_vld & w_rdy;
  assign w_ch   = r_mode & bus.in_ch;
  assign w_wrap = (r_cnt[w_ch] == r_rate);

  // Configuration is captured only on the final clear cycle, so a load arriving
  // mid-flush restarts the count and the newest mode/rate win.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      r_state <= ST_INIT;
      r_fcnt  <= '0;
      r_mode  <= 1'b0;
      r_rate  <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (w_last) begin
            r_state <= ST_RUN;
            r_fcnt  <= '0;
            r_mode  <= bus.mode;
            r_rate  <= bus.rate;
          end else begin
            r_fcnt <= r_fcnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.load) begin
            r_state <= ST_FLUSH;
            r_fcnt  <= '0;
          end
        end
        ST_FLUSH: begin
          if (bus.load) begin
            r_fcnt <= '0;
          end else if (w_last) begin
            r_state <= ST_RUN;
            r_fcnt  <= '0;
            r_mode  <= bus.mode;
            r_rate  <= bus.rate;
          end else begin
            r_fcnt <= r_fcnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_fcnt  <= '0;
        end
      endcase
    end
  end

  // Phase is forced low on the edge into FLUSH so it reads 0 for the whole clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= 1'b0;
    end else begin
      r_phase <= w_run & ~bus.load & r_mode & ~r_phase;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: this two-entry array is plain flops, not a RAM, so it is safe to
    // reset; large storage arrays should not carry a reset.
    if (!rst) begin
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
      r_dec_stb <= 1'b0;
      r_dec_ch  <= 1'b0;
    end else begin
      r_dec_stb <= w_acc & w_wrap;
      if (!w_run) begin
        for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
      end else if (w_acc) begin
        r_cnt[w_ch] <= w_wrap ? '0 : r_cnt[w_ch] + 1'b1;
      end
      if (w_acc & w_wrap) r_dec_ch <= w_ch;
    end
  end

  assign bus.in_rdy   = w_rdy;
  assign bus.int_zero = ~w_acc;
  assign bus.int_n    = r_mode;
  assign bus.int_rst  = ~w_run;
  assign bus.busy     = ~w_run;
  assign bus.dec_stb  = r_dec_stb;
  assign bus.dec_ch   = r_dec_ch;

endmodule

// File: tb/tb_cic_sched.sv
// Self-checking bench for cic_sched: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a sample-count model.
module tb_cic_sched;
  localparam int CNTW  = 12;
  localparam int FLUSH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cic_sched_if #(.CNTW(CNTW)) bus ();

  cic_sched #(.CNTW(CNTW), .FLUSH(FLUSH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: busy cycles left, edges spent in RUN (phase parity) and accepted samples
  // per channel since RUN began; a decimation happens on every R-th accept.
  bit m_run, m_flushing, m_mode, m_stb, m_dch;
  int m_left, m_runcyc, m_rate;
  int m_acc [2];

  function automatic void model_reset();
    m_run = 0; m_flushing = 0; m_mode = 0; m_stb = 0; m_dch = 0;
    m_left = FLUSH; m_runcyc = 0; m_rate = 0;
    m_acc[0] = 0; m_acc[1] = 0;
  endfunction

  function automatic bit exp_rdy();
    if (!rst || !m_run || bus.load) return 1'b0;
    if (!m_mode) return 1'b1;
    return bus.in_ch == bit'(m_runcyc % 2);
  endfunction

  function automatic void model_step();
    bit a, ch;
    a  = bus.in_vld && exp_rdy();
    ch = m_mode && bus.in_ch;
    m_stb = 0;
    if (a) begin
      m_acc[ch]++;
      if (m_acc[ch] % (m_rate + 1) == 0) begin
        m_stb = 1;
        m_dch = ch;
      end
    end
    if (m_run) begin
      if (bus.load) begin
        m_run = 0; m_flushing = 1; m_left = FLUSH;
      end else begin
        m_runcyc++;
      end
    end else if (m_flushing && bus.load) begin
      m_left = FLUSH;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_run = 1; m_runcyc = 0;
        m_mode = bus.mode; m_rate = int'(bus.rate);
        m_acc[0] = 0; m_acc[1] = 0;
      end
    end
  endfunction

  always @(negedge rst) model_reset();

  initial begin
    bit r;
    model_reset();
    forever begin
      @(negedge clk);
      #2;
      if (!rst) model_reset();
      r = exp_rdy();
      check("in_rdy",   bus.in_rdy,   r);
      check("int_zero", bus.int_zero, !(bus.in_vld && r));
      check("int_n",    bus.int_n,    m_mode);
      check("int_rst",  bus.int_rst,  !m_run);
      check("busy",     bus.busy,     !m_run);
      check("dec_stb",  bus.dec_stb,  m_stb);
      check("dec_ch",   bus.dec_ch,   m_dch);
      @(posedge clk);
      if (!rst) model_reset();
      else model_step();
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic wait_run();
    int n = 0;
    while (bus.busy && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("wait_run_bound", n < 50, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},   bus.in_rdy,   0);
    check({tag, "_zero"},  bus.int_zero, 1);
    check({tag, "_intn"},  bus.int_n,    0);
    check({tag, "_irst"},  bus.int_rst,  1);
    check({tag, "_stb"},   bus.dec_stb,  0);
    check({tag, "_ch"},    bus.dec_ch,   0);
    check({tag, "_busy"},  bus.busy,     1);
  endtask

  initial begin
    int n;
    logic [31:0] mask;
    logic [3:0]  seq;
    bit prev;
    int rst_hold;

    bus.mode = 0; bus.rate = 12'd3; bus.load = 0; bus.in_vld = 0; bus.in_ch = 0;

    // Reset release: INIT holds busy for FLUSH cycles.
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("rst_hold");
    @(negedge clk);
    rst = 1;
    #1;
    n = 0;
    while (bus.busy && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("init_len", n, FLUSH);
    check("init_rdy", bus.in_rdy, 1);
    check("init_intn", bus.int_n, 0);

    // mode 0, rate 3, twelve back-to-back samples.
    mask = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      bus.in_vld = (k <= 12);
      #1;
      if (bus.dec_stb) begin
        mask[k] = 1'b1;
        check("r3_ch", bus.dec_ch, 0);
      end
    end
    check("r3_stb_cycles", mask, 32'h0000_2220);

    // mode 1, rate 1, in_ch tracking the slot phase.
    @(negedge clk); bus.load = 1; bus.mode = 1; bus.rate = 12'd1; bus.in_vld = 0;
    @(negedge clk); bus.load = 0;
    wait_run();
    check("m1_intn", bus.int_n, 1);
    n = 0; seq = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.in_vld = (k <= 8);
      bus.in_ch  = k[0];
      #1;
      if (bus.dec_stb) begin
        n++;
        seq = {seq[2:0], bus.dec_ch};
      end
    end
    check("m1_stb_count", n, 4);
    check("m1_ch_seq", seq, 4'b1010);

    // mode 1, in_ch stuck at 0: ready alternates, rejected cycles zero the input.
    @(negedge clk); bus.in_vld = 1; bus.in_ch = 0;
    #1 prev = bus.in_rdy;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      check("m1_rdy_toggle", bus.in_rdy, !prev);
      check("m1_zero_rej", bus.int_zero, !bus.in_rdy);
      prev = bus.in_rdy;
    end

    // Load right after a decimating accept; then rate 0 decimates every sample.
    @(negedge clk); bus.load = 1; bus.mode = 0; bus.rate = 12'd1; bus.in_vld = 0;
    @(negedge clk); bus.load = 0;
    wait_run();
    @(negedge clk); bus.in_vld = 1;
    @(negedge clk); bus.in_vld = 1;
    @(negedge clk); bus.load = 1; bus.rate = 12'd0;
    #1;
    check("ld_stb_kept", bus.dec_stb, 1);
    check("ld_rdy_low", bus.in_rdy, 0);
    n = 1;
    @(negedge clk); bus.load = 0;
    #1;
    while (!bus.in_rdy && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("flush_rdy_low_len", n, FLUSH + 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 check("r0_stb", bus.dec_stb, 1);
    end

    // Reset mid-FLUSH.
    @(negedge clk); bus.load = 1;
    @(negedge clk); bus.load = 0; bus.in_vld = 0;
    @(negedge clk);
    #3 rst = 0;
    #1 check_reset_outputs("rst_flush");
    @(negedge clk);
    @(negedge clk); rst = 1;
    wait_run();

    // Reset mid-RUN while a strobe is out.
    @(negedge clk); bus.in_vld = 1;
    @(posedge clk);
    #1 check("pre_rst_stb", bus.dec_stb, 1);
    rst = 0;
    #1 check_reset_outputs("rst_run");
    @(negedge clk); bus.in_vld = 0;
    @(negedge clk); rst = 1;
    wait_run();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 check("post_rst_no_stb", bus.dec_stb, 0);
    end

    // Randomized traffic, configuration changes and occasional resets.
    rst_hold = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1;
      end else if ($urandom_range(0, 499) == 0) begin
        rst = 0;
        rst_hold = 2;
      end
      bus.in_vld = ($urandom_range(0, 3) != 0);
      bus.in_ch  = 1'($urandom);
      bus.load   = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) bus.mode = 1'($urandom);
      bus.rate   = ($urandom_range(0, 15) == 0) ? CNTW'($urandom) : CNTW'($urandom_range(0, 4));
    end
    @(negedge clk);
    rst = 1; bus.load = 0; bus.in_vld = 0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cic_sched.md
CIC_SCHED -- requirements
Module: cic_sched

Interface
REQ-001 Parameter CNTW, default 12, width of the decimation rate and sample counters.
REQ-002 Parameter FLUSH, default 4, number of cycles int_rst is held during initialisation and reconfiguration (min 2).
REQ-003 clk  in  1  single system clock; all logic is rising-edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 mode  in  1  requested channel mode: 0 = single channel, 1 = two interleaved channels.
REQ-006 rate  in  CNTW  requested decimation ratio minus one (R = rate+1, so 0 gives R=1).
REQ-007 load  in  1  one-cycle request to apply mode/rate.
REQ-008 in_vld  in  1  input sample valid.
REQ-009 in_ch  in  1  channel tag of the offered sample; ignored when mode=0.
REQ-010 in_rdy  out  1  sample accepted when in_vld and in_rdy are both 1.
REQ-011 int_zero  out  1  forces the integrator-chain input to zero this cycle.
REQ-012 int_n  out  1  integrator delay select: 1 = two-channel feedback.
REQ-013 int_rst  out  1  synchronous active-high clear to the integrator chain.
REQ-014 dec_stb  out  1  one-cycle strobe: the integrator output holds a decimated sample.
REQ-015 dec_ch  out  1  channel of the sample flagged by dec_stb.
REQ-016 busy  out  1  high in INIT and FLUSH.

Function
REQ-017 The state machine SHALL have the states INIT, RUN and FLUSH; it enters INIT on reset and moves from INIT to RUN after FLUSH cycles.
REQ-018 In RUN, load=1 SHALL move to FLUSH; FLUSH SHALL last FLUSH cycles and then return to RUN.
REQ-019 mode and rate SHALL be latched on the last cycle of INIT and FLUSH; int_n SHALL equal the latched mode.
REQ-020 int_rst and busy SHALL be 1 throughout INIT and FLUSH and 0 in RUN.
REQ-021 The slot phase register SHALL be cleared in INIT/FLUSH; in RUN it SHALL toggle every clock when latched mode=1 and stay 0 when mode=0.
REQ-022 In RUN with mode=1, in_rdy SHALL be (phase==in_ch); with mode=0, in_rdy SHALL be 1; in_rdy SHALL be 0 outside RUN and whenever load=1.
REQ-023 int_zero SHALL be the combinational inverse of (in_vld and in_rdy).
REQ-024 There SHALL be one CNTW-bit counter per channel, cleared in INIT/FLUSH and advanced only on an accepted sample of its channel (channel 0 when mode=0).
REQ-025 On acceptance with counter==latched rate, the counter SHALL wrap to 0 and a decimation event SHALL be flagged; otherwise the counter SHALL increment.
REQ-026 dec_stb SHALL assert exactly one cycle after the accepting cycle, with dec_ch = the accepted channel (registered), to match the one-register integrator latency.
REQ-027 When latched rate=0, every accepted sample SHALL produce dec_stb.
REQ-028 A decimation event flagged in the last RUN cycle before FLUSH SHALL still produce its dec_stb.
REQ-029 dec_stb SHALL never assert for a cycle in which int_rst was 1 on the previous edge, other than the case in REQ-028.
REQ-030 load during FLUSH SHALL restart the FLUSH count; the values latched are those present on the final FLUSH cycle.
REQ-031 Unaccepted offers (in_vld=1, in_rdy=0) SHALL not change any counter.

Reset
REQ-032 Asserting rst low SHALL, asynchronously, set state=INIT, phase=0, both counters=0, and clear the latched mode and rate.
REQ-033 While rst is low, outputs SHALL be in_rdy=0, int_zero=1, int_n=0, int_rst=1, dec_stb=0, dec_ch=0 and busy=1.
REQ-034 Releasing rst SHALL start the INIT count on the next rising edge; reset asserted during FLUSH SHALL abort it with no dec_stb.

Verification
REQ-035 Reset release with mode=0, rate=3 -> busy/int_rst high for 4 cycles, then RUN, in_rdy=1, int_n=0.
REQ-036 mode=0, rate=3, in_vld held 1 for 12 cycles -> dec_stb on cycles 5, 9 and 13 after the first accept, dec_ch=0.
REQ-037 mode=1, rate=1, alternating in_ch matching phase -> int_n=1, dec_stb every 2nd sample per channel, dec_ch alternating 0,1.
REQ-038 mode=1, in_ch held 0 -> in_rdy toggles each cycle, int_zero=1 on rejected cycles, channel 1 counter unchanged.
REQ-039 load with rate=0 issued the cycle after a decimating accept -> that dec_stb still fires, in_rdy=0 for FLUSH+1 cycles, then dec_stb on every accept.
REQ-040 rst pulsed low mid-FLUSH and mid-RUN -> all outputs take their REQ-033 values immediately, with no dec_stb afterwards until new accepts.
